// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: dual pre-add/sub lanes feeding dual multipliers
// (stage 1), then a post add/sub with an optional running accumulator
// (stage 2). Elastic valid/ready handshake on both sides, synchronous flush.
module alu_pipe #(
  parameter int unsigned W      = 8,
  parameter bit          ACC_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [W-1:0]           x0,
  input  logic [W-1:0]           x1,
  input  logic [W-1:0]           y0,
  input  logic [W-1:0]           y1,
  input  logic                   pre_x_en,
  input  logic                   pre_x_sub,
  input  logic                   pre_y_en,
  input  logic                   pre_y_sub,
  input  logic [2:0]             mul_x_sel,
  input  logic [2:0]             mul_y_sel,
  input  logic                   post_en,
  input  logic                   post_sub,
  input  logic                   acc_en,
  input  logic                   acc_clr,
  input  logic                   flush,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [2*(W+1)-1:0]     res_q,
  output logic                   carry_q,
  output logic [2*(W+1)-1:0]     acc_q,
  output logic [1:0]             inflight
);

  localparam int unsigned LW = W + 1;
  localparam int unsigned RW = 2 * LW;

  logic          v1, v2;
  logic          s1_adv, s2_adv, accept, s2_load;
  logic [LW-1:0] x_pre, y_pre, x_m1, y_m1;
  logic [RW-1:0] x_prod_d, y_prod_d;
  logic [RW-1:0] s1_x_prod, s1_y_prod;
  logic          s1_post_en, s1_post_sub, s1_acc_en, s1_acc_clr;
  logic [RW-1:0] b_sel, res_d;
  logic [RW:0]   post_sum;
  logic          carry_d;

  function automatic logic [LW-1:0] pre_add(input logic [W-1:0] in0,
                                            input logic [W-1:0] in1,
                                            input logic en,
                                            input logic sub);
    logic [LW-1:0] a, b;
    a = {1'b0, in0};
    b = {1'b0, in1};
    if (!en) return a;
    return sub ? (a - b) : (a + b);
  endfunction

  function automatic logic [LW-1:0] m1_pick(input logic [2:0]    sel,
                                            input logic [W-1:0]  in0,
                                            input logic [W-1:0]  in1,
                                            input logic [W-1:0]  other,
                                            input logic [LW-1:0] pre);
    logic [LW-1:0] m;
    case (sel)
      3'd0:    m = {1'b0, in0};
      3'd1:    m = {1'b0, in1};
      3'd2:    m = pre;
      3'd3:    m = {1'b0, other};
      3'd4:    m = {{(LW-1){1'b0}}, 1'b1};
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [RW-1:0] mul(input logic [LW-1:0] m0,
                                        input logic [LW-1:0] m1,
                                        input logic en);
    logic [RW-1:0] a, b;
    a = {{LW{1'b0}}, m0};
    b = {{LW{1'b0}}, m1};
    return en ? (a * b) : {m0, m1};
  endfunction

  // Handshake: stage 2 frees when empty or consumed; stage 1 when it can drain.
  always_comb begin
    s2_adv    = ~v2 | res_ready;
    s1_adv    = ~v1 | s2_adv;
    cmd_ready = s1_adv & ~flush;
    accept    = cmd_valid & cmd_ready;
    s2_load   = v1 & s2_adv & ~flush;
    res_valid = v2;
    inflight  = {1'b0, v1} + {1'b0, v2};
  end

  // Stage-1 datapath: pre-adders and multipliers for both lanes.
  always_comb begin
    x_pre    = pre_add(x0, x1, pre_x_en, pre_x_sub);
    y_pre    = pre_add(y0, y1, pre_y_en, pre_y_sub);
    x_m1     = m1_pick(mul_x_sel, x0, x1, y1, x_pre);
    y_m1     = m1_pick(mul_y_sel, y0, y1, x1, y_pre);
    x_prod_d = mul(x_pre, x_m1, pre_x_en);
    y_prod_d = mul(y_pre, y_m1, pre_y_en);
  end

  // Post adder reads live acc_q, so back-to-back accumulate ops chain without a hazard.
  always_comb begin
    b_sel    = (ACC_EN && s1_acc_en) ? (s1_acc_clr ? '0 : acc_q) : s1_y_prod;
    post_sum = '0;
    if (s1_post_en) begin
      post_sum = s1_post_sub ? ({1'b0, s1_x_prod} - {1'b0, b_sel})
                             : ({1'b0, s1_x_prod} + {1'b0, b_sel});
      res_d    = post_sum[RW-1:0];
      carry_d  = post_sum[RW];
    end else begin
      res_d    = {s1_x_prod[W:0], b_sel[W:0]};
      carry_d  = 1'b0;
    end
  end

  // Stage-1 register: capture products and post controls on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      s1_x_prod   <= '0;
      s1_y_prod   <= '0;
      s1_post_en  <= 1'b0;
      s1_post_sub <= 1'b0;
      s1_acc_en   <= 1'b0;
      s1_acc_clr  <= 1'b0;
    end else begin
      if (flush)       v1 <= 1'b0;
      else if (s1_adv) v1 <= accept;
      if (accept) begin
        s1_x_prod   <= x_prod_d;
        s1_y_prod   <= y_prod_d;
        s1_post_en  <= post_en;
        s1_post_sub <= post_sub;
        s1_acc_en   <= acc_en;
        s1_acc_clr  <= acc_clr;
      end
    end
  end

  // Stage-2 register: result holds while stalled; flush drops everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2      <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      if (flush)       v2 <= 1'b0;
      else if (s2_adv) v2 <= v1;
      if (s2_load) begin
        res_q   <= res_d;
        carry_q <= carry_d;
      end
    end
  end

  // Accumulator: updated as an accumulate op leaves stage 1; cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               acc_q <= '0;
    else if (flush)                           acc_q <= '0;
    else if (ACC_EN && s2_load && s1_acc_en)  acc_q <= res_d;
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (W=8): directed literal cases plus randomized traffic
// checked every cycle against an arithmetic reference model and scoreboard.
module tb_alu_pipe;

  logic        clk, rst_n;
  logic [7:0]  x0, x1, y0, y1;
  logic        pre_x_en, pre_x_sub, pre_y_en, pre_y_sub;
  logic [2:0]  mul_x_sel, mul_y_sel;
  logic        post_en, post_sub, acc_en, acc_clr, flush;
  logic        cmd_valid, cmd_ready, res_valid, res_ready, carry_q;
  logic [17:0] res_q, acc_q;
  logic [1:0]  inflight;

  alu_pipe #(.W(8), .ACC_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .pre_x_en(pre_x_en), .pre_x_sub(pre_x_sub),
    .pre_y_en(pre_y_en), .pre_y_sub(pre_y_sub),
    .mul_x_sel(mul_x_sel), .mul_y_sel(mul_y_sel),
    .post_en(post_en), .post_sub(post_sub),
    .acc_en(acc_en), .acc_clr(acc_clr), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_q(res_q), .carry_q(carry_q), .acc_q(acc_q), .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x0, x1, y0, y1;
    logic       pxe, pxs, pye, pys;
    logic [2:0] sx, sy;
    logic       pe, ps, ae, ac;
  } cmd_t;

  typedef struct {
    int unsigned res;
    logic        carry;
  } exp_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        eq[$];
  int unsigned macc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int unsigned pre_m(int unsigned a, int unsigned b, logic en, logic sub);
    if (!en) return a;
    return sub ? (a + 512 - b) % 512 : (a + b) % 512;
  endfunction

  function automatic int unsigned m1_m(logic [2:0] sel, int unsigned in0, int unsigned in1,
                                       int unsigned pre, int unsigned other);
    case (sel)
      3'd0: return in0;
      3'd1: return in1;
      3'd2: return pre;
      3'd3: return other;
      3'd4: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic void model(input cmd_t c, input int unsigned acc_in,
                                output int unsigned res, output logic carry);
    int unsigned xpre, ypre, xm1, ym1, xp, yp, b;
    xpre = pre_m(c.x0, c.x1, c.pxe, c.pxs);
    ypre = pre_m(c.y0, c.y1, c.pye, c.pys);
    xm1  = m1_m(c.sx, c.x0, c.x1, xpre, c.y1);
    ym1  = m1_m(c.sy, c.y0, c.y1, ypre, c.x1);
    xp   = c.pxe ? xpre * xm1 : xpre * 512 + xm1;
    yp   = c.pye ? ypre * ym1 : ypre * 512 + ym1;
    b    = c.ae ? (c.ac ? 0 : acc_in) : yp;
    carry = 1'b0;
    if (!c.pe) begin
      res = (xp % 512) * 512 + (b % 512);
    end else if (!c.ps) begin
      res   = (xp + b) % 262144;
      carry = (xp + b) >= 262144;
    end else if (xp >= b) begin
      res = xp - b;
    end else begin
      res   = xp + 262144 - b;
      carry = 1'b1;
    end
  endfunction

  function automatic cmd_t cur_cmd();
    cmd_t c;
    c = {x0, x1, y0, y1, pre_x_en, pre_x_sub, pre_y_en, pre_y_sub,
         mul_x_sel, mul_y_sel, post_en, post_sub, acc_en, acc_clr};
    return c;
  endfunction

  // ---------------- per-cycle compare against model ----------------
  always @(negedge clk) begin
    exp_t        e;
    int unsigned r;
    logic        cy;
    logic        rdy_exp;
    if (!rst_n) begin
      eq.delete();
      macc = 0;
    end else begin
      rdy_exp = !flush && (eq.size() < 2 || res_ready);
      chk("inflight", inflight, eq.size());
      chk("cmd_ready", cmd_ready, rdy_exp);
      if (eq.size() == 0) begin
        chk("idle_res_valid", res_valid, 0);
        chk("idle_acc_q", acc_q, macc);
      end else if (eq.size() == 2) begin
        chk("full_res_valid", res_valid, 1);
      end
      if (res_valid && res_ready) begin
        if (eq.size() == 0) chk("spurious_res_valid", res_valid, 0);
        else begin
          e = eq.pop_front();
          chk("res_q", res_q, e.res);
          chk("carry_q", carry_q, e.carry);
        end
      end
      if (flush) begin
        eq.delete();
        macc = 0;
      end else if (cmd_valid && rdy_exp) begin
        model(cur_cmd(), macc, r, cy);
        if (acc_en) macc = r;
        e.res = r;
        e.carry = cy;
        eq.push_back(e);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input cmd_t c);
    {x0, x1, y0, y1, pre_x_en, pre_x_sub, pre_y_en, pre_y_sub,
     mul_x_sel, mul_y_sel, post_en, post_sub, acc_en, acc_clr} = c;
  endtask

  function automatic cmd_t rand_cmd(input bit allow_acc);
    cmd_t c;
    c = cmd_t'({$urandom, $urandom});
    c.ae = allow_acc && ($urandom_range(0, 2) == 0);
    return c;
  endfunction

  task automatic drain();
    int n = 0;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    while (inflight != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_timeout", inflight, 0);
    tick();
  endtask

  task automatic send_one(input cmd_t c);
    set_cmd(c);
    cmd_valid = 1'b1;
    res_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    cmd_t        c;
    int unsigned r;
    logic        cy;
    rst_n = 1'b1;
    flush = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    set_cmd('0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_q", res_q, 0);
    chk("rst_carry_q", carry_q, 0);
    chk("rst_acc_q", acc_q, 0);
    chk("rst_inflight", inflight, 0);
    tick();
    rst_n = 1'b1;
    #1 chk("rst_cmd_ready", cmd_ready, 1);

    // Basic op and latency: 5*2 + 3*1 = 13
    c = '0;
    c.x0 = 3; c.x1 = 2; c.pxe = 1; c.sx = 1;
    c.y0 = 4; c.y1 = 1; c.pye = 1; c.pys = 1; c.sy = 4;
    c.pe = 1;
    model(c, 0, r, cy);
    chk("model_pin_basic", r, 13);
    set_cmd(c);
    cmd_valid = 1'b1;
    res_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("lat_n_res_valid", res_valid, 0);
    chk("lat_n_inflight", inflight, 1);
    tick();
    chk("lat_n1_res_valid", res_valid, 1);
    chk("basic_res_q", res_q, 13);
    chk("basic_carry_q", carry_q, 0);
    drain();

    // Backpressure: three commands offered, two taken while rx stalls
    res_ready = 1'b0;
    set_cmd(rand_cmd(0)); cmd_valid = 1'b1; tick();
    set_cmd(rand_cmd(0)); tick();
    set_cmd(rand_cmd(0)); tick();
    chk("bp_inflight", inflight, 2);
    chk("bp_cmd_ready", cmd_ready, 0);
    chk("bp_res_valid", res_valid, 1);
    res_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    drain();

    // Accumulate 4 x 10 with clear on the first
    c = '0;
    c.x0 = 10; c.pxe = 1; c.sx = 4; c.pe = 1; c.ae = 1;
    model(c, 30, r, cy);
    chk("model_pin_acc", r, 40);
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      c.ac = (k == 0);
      set_cmd(c);
      tick();
    end
    cmd_valid = 1'b0;
    drain();
    chk("acc_final_acc_q", acc_q, 40);
    chk("acc_final_res_q", res_q, 40);

    // Post subtract underflow: 2 - 5
    c = '0;
    c.x1 = 2; c.sx = 1; c.y1 = 5; c.sy = 1; c.pe = 1; c.ps = 1;
    send_one(c);
    drain();
    chk("sub_res_q", res_q, 18'h3FFFD);
    chk("sub_carry_q", carry_q, 1);

    // Everything bypassed: concatenation path
    c = '0;
    c.x0 = 8'hAB; c.y0 = 8'hCD; c.x1 = 8'h5A; c.y1 = 8'h33;
    send_one(c);
    drain();
    chk("bypass_res_q", res_q, 18'h156CD);
    chk("bypass_carry_q", carry_q, 0);

    // Flush with two ops in flight
    c = '0;
    c.x0 = 10; c.pxe = 1; c.sx = 4; c.pe = 1; c.ae = 1; c.ac = 1;
    res_ready = 1'b0;
    set_cmd(c); cmd_valid = 1'b1; tick();
    c.ac = 0; set_cmd(c); tick();
    chk("flush_pre_inflight", inflight, 2);
    chk("flush_pre_acc_q", acc_q, 10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cmd_valid = 1'b0;
    chk("flush_res_valid", res_valid, 0);
    chk("flush_acc_q", acc_q, 0);
    chk("flush_inflight", inflight, 0);
    drain();

    // Asynchronous reset mid-operation
    c.ac = 1;
    set_cmd(c); cmd_valid = 1'b1; tick();
    c.ac = 0; set_cmd(c); tick();
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("amid_res_valid", res_valid, 0);
    chk("amid_res_q", res_q, 0);
    chk("amid_carry_q", carry_q, 0);
    chk("amid_acc_q", acc_q, 0);
    chk("amid_inflight", inflight, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic with random backpressure and rare flushes
    for (int i = 0; i < 3000; i++) begin
      set_cmd(rand_cmd(1));
      cmd_valid = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 59) == 0);
      tick();
    end
    flush = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
